// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - shares the RTC register-bus engine between time refresh and user writes
// A free-running refresh timer requests a 3-register time read; user writes queue one deep.
module rtc_bus_arbiter #(
   parameter int          REFRESH_CYCLES = 100000,
   parameter int          TIMEOUT        = 255,
   parameter logic [7:0]  ADDR_SEG       = 8'h21,
   parameter logic [7:0]  ADDR_MIN       = 8'h22,
   parameter logic [7:0]  ADDR_HOR       = 8'h23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_busy,
   output logic       wr_ack,
   output logic       bus_start,
   output logic       bus_rw,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   input  logic       bus_done,
   input  logic [7:0] bus_rdata,
   output logic       bus_err,
   output logic [7:0] HRTC,
   output logic [7:0] MRTC,
   output logic [7:0] SRTC,
   output logic       time_valid
);

   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT} state_t;

   state_t          state, state_n;
   logic [RW-1:0]   ref_cnt;
   logic [TW-1:0]   to_cnt;
   logic            refresh_pend, wr_pend, last_grant_w;
   logic [7:0]      wr_addr_q, wr_data_q;
   logic [1:0]      idx;
   logic [7:0]      shadow_seg, shadow_min;
   logic            ref_tc, to_hit;
   logic            grant_w, grant_r, w_fin, r_step, r_fin, r_abort;

   assign ref_tc    = (ref_cnt == RW'(REFRESH_CYCLES - 1));
   assign to_hit    = !bus_done && (to_cnt == TW'(TIMEOUT - 1));
   assign bus_start = (state == W_ISSUE) || (state == R_ISSUE);
   assign wr_busy   = wr_pend;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // On a tie the requester that was not served last wins.
   always_comb begin
      state_n = state;
      grant_w = 1'b0;
      grant_r = 1'b0;
      w_fin   = 1'b0;
      r_step  = 1'b0;
      r_fin   = 1'b0;
      r_abort = 1'b0;
      case (state)
         IDLE: begin
            if (wr_pend && (!refresh_pend || !last_grant_w)) begin
               state_n = W_ISSUE;
               grant_w = 1'b1;
            end else if (refresh_pend) begin
               state_n = R_ISSUE;
               grant_r = 1'b1;
            end
         end
         W_ISSUE: state_n = W_WAIT;
         W_WAIT: begin
            if (bus_done || to_hit) begin
               state_n = IDLE;
               w_fin   = 1'b1;
            end
         end
         R_ISSUE: state_n = R_WAIT;
         R_WAIT: begin
            if (bus_done) begin
               if (idx == 2'd2) begin
                  state_n = IDLE;
                  r_fin   = 1'b1;
               end else begin
                  state_n = R_ISSUE;
                  r_step  = 1'b1;
               end
            end else if (to_hit) begin
               state_n = IDLE;
               r_abort = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt      <= '0;
         to_cnt       <= '0;
         refresh_pend <= 1'b0;
         wr_pend      <= 1'b0;
         last_grant_w <= 1'b0;
         wr_addr_q    <= 8'h00;
         wr_data_q    <= 8'h00;
         idx          <= 2'd0;
         shadow_seg   <= 8'h00;
         shadow_min   <= 8'h00;
         bus_rw       <= 1'b0;
         bus_addr     <= 8'h00;
         bus_wdata    <= 8'h00;
         wr_ack       <= 1'b0;
         bus_err      <= 1'b0;
         time_valid   <= 1'b0;
         HRTC         <= 8'h00;
         MRTC         <= 8'h00;
         SRTC         <= 8'h00;
      end else begin
         ref_cnt <= ref_tc ? '0 : ref_cnt + RW'(1);
         if (ref_tc)       refresh_pend <= 1'b1;
         else if (grant_r) refresh_pend <= 1'b0;

         if (!wr_pend && wr_req) begin
            wr_pend   <= 1'b1;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
         end else if (w_fin) begin
            wr_pend <= 1'b0;
         end

         if (bus_start)                              to_cnt <= '0;
         else if (state == W_WAIT || state == R_WAIT) to_cnt <= to_cnt + TW'(1);

         wr_ack     <= w_fin;
         bus_err    <= (w_fin && !bus_done) || r_abort;
         time_valid <= r_fin;

         if (grant_w) begin
            bus_rw    <= 1'b0;
            bus_addr  <= wr_addr_q;
            bus_wdata <= wr_data_q;
         end
         if (grant_r) begin
            idx      <= 2'd0;
            bus_rw   <= 1'b1;
            bus_addr <= ADDR_SEG;
         end
         if (r_step) begin
            idx <= idx + 2'd1;
            if (idx == 2'd0) begin
               shadow_seg <= bus_rdata;
               bus_addr   <= ADDR_MIN;
            end else begin
               shadow_min <= bus_rdata;
               bus_addr   <= ADDR_HOR;
            end
         end
         // Hours arrive in the final done cycle, so they bypass the shadows.
         if (r_fin) begin
            SRTC <= shadow_seg;
            MRTC <= shadow_min;
            HRTC <= bus_rdata;
         end
         if (r_fin || r_abort) begin
            idx          <= 2'd0;
            last_grant_w <= 1'b0;
         end
         if (w_fin) last_grant_w <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - self-checking bench for rtc_bus_arbiter
// Transaction-level model of expected bus traffic, with a responding engine.
module tb_rtc_bus_arbiter;
   localparam int R  = 300;
   localparam int TO = 255;

   logic       clk = 1'b0, reset = 1'b1, wr_req = 1'b0, bus_done = 1'b0;
   logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, bus_rdata = 8'h00;
   logic       wr_busy, wr_ack, bus_start, bus_rw, bus_err, time_valid;
   logic [7:0] bus_addr, bus_wdata, hrtc, mrtc, srtc;

   always #5 clk = ~clk;

   rtc_bus_arbiter #(.REFRESH_CYCLES(R), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_busy(wr_busy), .wr_ack(wr_ack), .bus_start(bus_start), .bus_rw(bus_rw),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata),
      .bus_err(bus_err), .HRTC(hrtc), .MRTC(mrtc), .SRTC(srtc), .time_valid(time_valid)
   );

   typedef struct packed {logic rw; logic [7:0] addr; logic [7:0] wdata;} op_t;

   op_t        log_q[$], exp_q[$];
   int         st_cyc[$];
   logic [7:0] mem [0:255];
   int         cyc = 0, delay = 2, drop_at = 0, nstart = 0;
   int         ack_cnt = 0, tv_cnt = 0, err_cnt = 0, busy_cnt = 0;
   int         ack_cyc = 0, tv_cyc = 0, err_cyc = 0;
   logic       force_done = 1'b0;
   bit         model_last_w = 1'b0;
   int         checks = 0, errors = 0;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Engine and monitor: bus_done arrives `delay` cycles after bus_start.
   initial begin
      int cd;
      logic [7:0] rd;
      cd = 0;
      rd = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         if (wr_ack)     begin ack_cnt++; ack_cyc = cyc; end
         if (time_valid) begin tv_cnt++;  tv_cyc  = cyc; end
         if (bus_err)    begin err_cnt++; err_cyc = cyc; end
         if (wr_busy)    busy_cnt++;
         bus_done = 1'b0;
         if (reset) cd = 0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin bus_done = 1'b1; bus_rdata = rd; end
         end
         if (force_done) bus_done = 1'b1;
         if (bus_start && !reset) begin
            nstart++;
            log_q.push_back(op_t'{bus_rw, bus_addr, bus_wdata});
            st_cyc.push_back(cyc);
            rd = mem[bus_addr];
            if (nstart != drop_at) cd = delay;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_burst();
      exp_q.push_back(op_t'{1'b1, 8'h21, 8'h00});
      exp_q.push_back(op_t'{1'b1, 8'h22, 8'h00});
      exp_q.push_back(op_t'{1'b1, 8'h23, 8'h00});
      model_last_w = 1'b0;
   endfunction

   function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back(op_t'{1'b0, a, d});
      model_last_w = 1'b1;
   endfunction

   function automatic void m_tie(input logic [7:0] a, input logic [7:0] d);
      if (model_last_w) begin m_burst(); m_write(a, d); end
      else begin m_write(a, d); m_burst(); end
   endfunction

   task automatic check_ops(input int b, input string tag);
      chk({tag, "_count"}, log_q.size() - b, exp_q.size());
      for (int i = 0; i < exp_q.size() && b + i < log_q.size(); i++) begin
         chk({tag, "_rw"}, log_q[b+i].rw, exp_q[i].rw);
         chk({tag, "_addr"}, log_q[b+i].addr, exp_q[i].addr);
         if (!exp_q[i].rw) chk({tag, "_wdata"}, log_q[b+i].wdata, exp_q[i].wdata);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_last_w = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_wr(input logic [7:0] a, input logic [7:0] d);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_req = 1'b0;
   endtask

   initial begin
      int b, ab, tb, eb, bb, s2;
      logic [7:0] a, d, a2, d2, sh, sm, ss;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_wr_busy", wr_busy, 0);
      chk("rst_bus_start", bus_start, 0);
      chk("rst_bus_rw", bus_rw, 0);
      chk("rst_bus_addr_wdata", {bus_addr, bus_wdata}, 0);
      chk("rst_time_regs", {hrtc, mrtc, srtc}, 0);
      chk("rst_pulses", {wr_ack, bus_err, time_valid}, 0);

      // Refresh bursts: first one with fixed data, then randomized data and latency.
      for (int it = 0; it < 3; it++) begin
         if (it == 0) begin
            mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12; delay = 2;
         end else begin
            mem[8'h21] = 8'($urandom); mem[8'h22] = 8'($urandom); mem[8'h23] = 8'($urandom);
            delay = $urandom_range(1, 6);
         end
         do_reset();
         b = log_q.size(); tb = tv_cnt;
         m_burst();
         for (int i = 0; i < R + 100 && tv_cnt == tb; i++) @(negedge clk);
         repeat (5) @(negedge clk);
         chk("rd_tv_count", tv_cnt - tb, 1);
         check_ops(b, "rd_ops");
         if (log_q.size() > b) chk("rd_first_start", st_cyc[b], R + 1);
         chk("rd_tv_cycle", tv_cyc, R + 1 + 3 * (delay + 1));
         chk("rd_srtc", srtc, mem[8'h21]);
         chk("rd_mrtc", mrtc, mem[8'h22]);
         chk("rd_hrtc", hrtc, mem[8'h23]);
      end

      // Isolated writes.
      for (int it = 0; it < 3; it++) begin
         a = (it == 0) ? 8'h41 : 8'($urandom);
         d = (it == 0) ? 8'h59 : 8'($urandom);
         delay = $urandom_range(1, 6);
         do_reset();
         wait_until(10);
         b = log_q.size(); ab = ack_cnt; bb = busy_cnt;
         m_write(a, d);
         pulse_wr(a, d);
         chk("wr_busy_rise", wr_busy, 1);
         for (int i = 0; i < 50 && ack_cnt == ab; i++) @(negedge clk);
         repeat (3) @(negedge clk);
         chk("wr_ack_count", ack_cnt - ab, 1);
         check_ops(b, "wr_ops");
         if (log_q.size() > b) chk("wr_start_cycle", st_cyc[b], 12);
         chk("wr_ack_cycle", ack_cyc, 13 + delay);
         chk("wr_busy_cycles", busy_cnt - bb, delay + 2);
         chk("wr_bus_hold", {bus_rw, bus_addr, bus_wdata}, {1'b0, a, d});
      end

      // Write arriving mid-burst waits; a second request while busy is dropped.
      do_reset();
      delay = 2;
      a = 8'($urandom); d = 8'($urandom); a2 = ~a; d2 = ~d;
      b = log_q.size(); ab = ack_cnt;
      for (int i = 0; i < R + 50 && log_q.size() < b + 2; i++) @(negedge clk);
      m_burst(); m_write(a, d);
      pulse_wr(a, d);
      repeat (2) @(negedge clk);
      pulse_wr(a2, d2);
      for (int i = 0; i < 100 && ack_cnt == ab; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("mid_ack_count", ack_cnt - ab, 1);
      check_ops(b, "mid_ops");

      // Tie right after reset: write is granted first.
      do_reset();
      delay = 1;
      a = 8'($urandom); d = 8'($urandom);
      b = log_q.size(); ab = ack_cnt; tb = tv_cnt;
      wait_until(R - 1);
      m_tie(a, d);
      pulse_wr(a, d);
      for (int i = 0; i < 100 && (ack_cnt == ab || tv_cnt == tb); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_ops(b, "tie1_ops");
      if (log_q.size() > b) chk("tie1_start", st_cyc[b], R + 1);

      // Tie after a write was served last: read burst is granted first.
      do_reset();
      a = 8'($urandom); d = 8'($urandom); a2 = 8'($urandom); d2 = 8'($urandom);
      b = log_q.size(); ab = ack_cnt; tb = tv_cnt;
      wait_until(10);
      m_write(a, d);
      pulse_wr(a, d);
      for (int i = 0; i < 50 && ack_cnt == ab; i++) @(negedge clk);
      ab = ack_cnt;
      wait_until(R - 1);
      m_tie(a2, d2);
      pulse_wr(a2, d2);
      for (int i = 0; i < 100 && (ack_cnt == ab || tv_cnt == tb); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_ops(b, "tie2_ops");

      // Read timeout on the second register of the next burst.
      do_reset();
      delay = 2;
      mem[8'h21] = 8'($urandom); mem[8'h22] = 8'($urandom); mem[8'h23] = 8'($urandom);
      ss = mem[8'h21]; sm = mem[8'h22]; sh = mem[8'h23];
      tb = tv_cnt;
      for (int i = 0; i < R + 100 && tv_cnt == tb; i++) @(negedge clk);
      mem[8'h21] = ~ss; mem[8'h22] = ~sm; mem[8'h23] = ~sh;
      drop_at = nstart + 2;
      b = log_q.size(); tb = tv_cnt; eb = err_cnt;
      for (int i = 0; i < R + 400 && err_cnt == eb; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("rto_err_count", err_cnt - eb, 1);
      s2 = (log_q.size() > b + 1) ? st_cyc[b+1] : -1000;
      chk("rto_err_cycle", err_cyc, s2 + TO + 1);
      chk("rto_no_tv", tv_cnt - tb, 0);
      chk("rto_time_regs", {hrtc, mrtc, srtc}, {sh, sm, ss});
      a = 8'($urandom); d = 8'($urandom); ab = ack_cnt;
      pulse_wr(a, d);
      for (int i = 0; i < 50 && ack_cnt == ab; i++) @(negedge clk);
      chk("rto_next_ack", ack_cnt - ab, 1);
      chk("rto_log_size", log_q.size() - b, 3);
      if (log_q.size() > 0) chk("rto_next_op", log_q[log_q.size()-1], {1'b0, a, d});

      // Write timeout: ack and error together, busy released.
      do_reset();
      drop_at = nstart + 1;
      wait_until(10);
      ab = ack_cnt; eb = err_cnt;
      pulse_wr(8'h10, 8'h20);
      for (int i = 0; i < 400 && ack_cnt == ab; i++) @(negedge clk);
      chk("wto_ack_cycle", ack_cyc, 12 + TO + 1);
      chk("wto_err_count", err_cnt - eb, 1);
      chk("wto_err_cycle", err_cyc, 12 + TO + 1);
      chk("wto_busy", wr_busy, 0);

      // Reset inside W_WAIT, then a late bus_done.
      do_reset();
      drop_at = nstart + 1;
      wait_until(10);
      pulse_wr(8'h33, 8'h44);
      wait_until(20);
      ab = ack_cnt; eb = err_cnt; tb = tv_cnt;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("rmid_pulses", {ack_cnt - ab, err_cnt - eb, tv_cnt - tb}, 0);
      chk("rmid_busy", wr_busy, 0);
      chk("rmid_bus", {bus_start, bus_rw, bus_addr, bus_wdata}, 0);
      chk("rmid_time_regs", {hrtc, mrtc, srtc}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Sequences and shares the single RTC register-bus transaction engine between two requesters: a periodic time-refresh reader that keeps the BCD hour/minute/second registers current for the alarm/countdown logic and display, and a user configuration writer. The block sits between the user-control FSM, the transaction engine and the consumers of HRTC/MRTC/SRTC. It issues one bus transaction at a time over a start/done handshake and enforces a bus timeout.

## Interface
Parameters:
- REFRESH_CYCLES, 100000: period of the automatic time-refresh request, in clk cycles.
- TIMEOUT, 255: maximum number of cycles spent waiting for bus_done before abort.
- ADDR_SEG, 8'h21: RTC seconds register address.
- ADDR_MIN, 8'h22: RTC minutes register address.
- ADDR_HOR, 8'h23: RTC hours register address.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  one-cycle write request pulse; wr_addr/wr_data are sampled in the same cycle.
- wr_addr  in  8  target register address.
- wr_data  in  8  write data.
- wr_busy  out  1  high while a write is pending or in flight.
- wr_ack  out  1  one-cycle pulse when the write completes or times out.
- bus_start  out  1  one-cycle pulse that launches a transaction.
- bus_rw  out  1  1 = read, 0 = write.
- bus_addr  out  8  transaction address.
- bus_wdata  out  8  write data.
- bus_done  in  1  one-cycle completion pulse from the engine.
- bus_rdata  in  8  read data; valid only in the bus_done cycle.
- bus_err  out  1  one-cycle pulse on timeout.
- HRTC, MRTC, SRTC  out  8 each  BCD hour, minute and second registers.
- time_valid  out  1  one-cycle pulse when HRTC/MRTC/SRTC are updated.

## Operation
- Refresh counter runs free from 0 to REFRESH_CYCLES-1. At the terminal count it sets refresh_pend and wraps to 0. Setting an already-set refresh_pend has no further effect (requests do not accumulate).
- When wr_busy=0, a wr_req pulse latches wr_addr/wr_data and sets wr_pend (wr_busy=1). When wr_busy=1, wr_req is ignored.
- FSM states: IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT.
- IDLE arbitration:
  - Only wr_pend set: go to W_ISSUE.
  - Only refresh_pend set: go to R_ISSUE with idx=0 and clear refresh_pend.
  - Both set: the requester not granted last wins. last_grant resets to "read", so the first tie after reset goes to the write.
- W_ISSUE: bus_start=1, bus_rw=0, bus_addr/bus_wdata = latched values. Next state is W_WAIT.
- W_WAIT: on bus_done, pulse wr_ack, clear wr_pend, set last_grant=write, go to IDLE.
- R_ISSUE: bus_start=1, bus_rw=1, bus_addr = ADDR_SEG, ADDR_MIN, ADDR_HOR for idx 0, 1, 2 respectively. Next state is R_WAIT.
- R_WAIT: on bus_done, store bus_rdata into a shadow register [idx].
  - If idx<2: idx+1, go to R_ISSUE.
  - If idx=2: copy all three shadows into SRTC/MRTC/HRTC in the same cycle, pulse time_valid, set last_grant=read, go to IDLE.
- A read burst is atomic: a write arriving mid-burst waits until the burst finishes.
- Timeout counter: cleared on entry to any WAIT state and incremented each WAIT cycle without bus_done. On reaching TIMEOUT:
  - pulse bus_err and go to IDLE;
  - write: also pulse wr_ack and clear wr_pend;
  - read: discard the shadow registers; HRTC/MRTC/SRTC are unchanged and time_valid is not pulsed;
  - last_grant is updated exactly as on success.
- bus_done outside a WAIT state is ignored.
- bus_addr, bus_rw and bus_wdata hold stable from ISSUE through the end of WAIT. Between transactions they hold their last value.

## Timing
- Reset values:
  - outputs: wr_busy, wr_ack, bus_start, bus_rw, bus_err and time_valid = 0; bus_addr, bus_wdata, HRTC, MRTC and SRTC = 8'h00;
  - internal: state IDLE, refresh counter 0, refresh_pend=0, wr_pend=0, idx=0.
- Reset asserted mid-transaction aborts it. No wr_ack, time_valid or bus_err is emitted, and a later bus_done is ignored.
- wr_busy rises in the cycle after the accepted wr_req.
- The earliest bus_start is one cycle after the pend flag is set, i.e. IDLE→ISSUE takes one cycle.
- Write latency: wr_ack is registered and rises one cycle after the bus_done cycle. wr_busy falls together with wr_ack.
- Read burst: 3 × (1 ISSUE cycle + WAIT cycles). HRTC/MRTC/SRTC and time_valid change one cycle after the third bus_done.
- A refresh terminal count and a wr_req in the same cycle set both pend flags, and IDLE arbitration then applies.
- The earliest bus_done accepted is the cycle after bus_start.

## Test plan
- Reset, engine returns bus_done 2 cycles after each start with rdata 8'h45, 8'h30, 8'h12; let refresh fire → exactly 3 reads at 8'h21, 8'h22, 8'h23; then SRTC=8'h45, MRTC=8'h30, HRTC=8'h12 and time_valid pulses once.
- wr_req with addr 8'h41, data 8'h59 while idle → one bus_start with bus_rw=0, addr 8'h41, wdata 8'h59; wr_ack one cycle after bus_done; wr_busy high over that interval.
- wr_req during idx=1 of a read burst → the burst completes all 3 reads uninterrupted, then the write issues; a second wr_req while wr_busy=1 is ignored (only one write on the bus).
- refresh_pend and wr_pend set in the same cycle right after reset → write granted first; repeat the tie after that write → read burst granted.
- Engine never returns bus_done on the second read → bus_err after 255 WAIT cycles, time registers unchanged, no time_valid, FSM back in IDLE and serving the next request.
- Reset asserted in W_WAIT followed by a late bus_done → no wr_ack, all outputs at reset values, wr_busy=0.
